// File: rtl/rgb_sequencer.sv
// RGB breathing sequencer: each colour ramps up then down in STEP increments per tick,
// driving its active-low LED with a PWM compare against a free-running counter.
module rgb_sequencer #(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick,
  output logic       RGB0,
  output logic       RGB1,
  output logic       RGB2,
  output logic [1:0] color,
  output logic       seq_done
);

  localparam logic [PWM_BITS-1:0] MAX_V  = '1;
  localparam logic [PWM_BITS-1:0] STEP_V = PWM_BITS'(STEP);

  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, BLUE = 2'd2} color_t;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} phase_t;

  // Declaration values mirror reset so the part powers up in the reset state.
  color_t              state   = RED;
  phase_t              phase   = UP;
  logic [PWM_BITS-1:0] level   = '0;
  logic [PWM_BITS-1:0] pwm_cnt = '0;
  logic [2:0]          rgb_p1  = 3'b111;
  logic                done_p1 = 1'b0;

  color_t              state_nxt;
  phase_t              phase_nxt;
  logic [PWM_BITS-1:0] level_nxt;
  logic                done_nxt;
  logic                state_bad;
  logic                pwm_on;

  function automatic logic [PWM_BITS-1:0] sat_up(input logic [PWM_BITS-1:0] l);
    return (l >= MAX_V - STEP_V) ? MAX_V : l + STEP_V;
  endfunction

  function automatic logic [PWM_BITS-1:0] sat_down(input logic [PWM_BITS-1:0] l);
    return (l <= STEP_V) ? '0 : l - STEP_V;
  endfunction

  assign state_bad = (2'(state) == 2'b11);
  assign pwm_on    = (pwm_cnt < level);

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    level_nxt = level;
    done_nxt  = 1'b0;
    if (state_bad) begin
      state_nxt = RED;
    end else if (tick) begin
      if (phase == UP) begin
        level_nxt = sat_up(level);
        if (level >= MAX_V - STEP_V) phase_nxt = DOWN;
      end else begin
        level_nxt = sat_down(level);
        if (level <= STEP_V) begin
          phase_nxt = UP;
          case (state)
            RED:     state_nxt = GREEN;
            GREEN:   state_nxt = BLUE;
            default: begin
              state_nxt = RED;
              done_nxt  = 1'b1;
            end
          endcase
        end
      end
    end
  end

  // Stage p0: sequencer state and PWM counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RED;
      phase   <= UP;
      level   <= '0;
      pwm_cnt <= '0;
    end else if (en) begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      level   <= level_nxt;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else if (state_bad) begin
      state   <= RED;
    end
  end

  // Stage p1: registered LED drive and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p1  <= 3'b111;
      done_p1 <= 1'b0;
    end else if (en) begin
      rgb_p1[0] <= !(pwm_on && state == RED);
      rgb_p1[1] <= !(pwm_on && state == GREEN);
      rgb_p1[2] <= !(pwm_on && state == BLUE);
      done_p1   <= done_nxt;
    end else begin
      done_p1 <= 1'b0;
    end
  end

  assign RGB0     = rgb_p1[0];
  assign RGB1     = rgb_p1[1];
  assign RGB2     = rgb_p1[2];
  assign color    = state;
  assign seq_done = done_p1;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Bench for rgb_sequencer: two instances (STEP=1 and STEP=100) on shared stimulus,
// checked against an arithmetic reference model plus directed duty-cycle measurements.
module tb_rgb_sequencer;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, tick = 1'b0;
  logic a0, a1, a2, ad;
  logic b0, b1, b2, bd;
  logic [1:0] ac, bc;

  rgb_sequencer #(.PWM_BITS(8), .STEP(1)) dut_s1 (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .RGB0(a0), .RGB1(a1), .RGB2(a2), .color(ac), .seq_done(ad));

  rgb_sequencer #(.PWM_BITS(8), .STEP(100)) dut_s100 (
    .clk(clk), .rst(rst), .en(en), .tick(tick),
    .RGB0(b0), .RGB1(b1), .RGB2(b2), .color(bc), .seq_done(bd));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: level as a clamped triangle, pwm as a cycle count mod 256.
  int steps[2] = '{1, 100};
  int m_cnt = 0;
  int m_lvl[2] = '{0, 0};
  bit m_up[2] = '{1, 1};
  int m_col[2] = '{0, 0};
  int m_rgb[2] = '{7, 7};
  int m_done[2] = '{0, 0};

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      for (int i = 0; i < 2; i++) begin
        m_lvl[i] = 0; m_up[i] = 1; m_col[i] = 0; m_rgb[i] = 7; m_done[i] = 0;
      end
    end else if (en) begin
      for (int i = 0; i < 2; i++) begin
        m_rgb[i] = (m_cnt < m_lvl[i]) ? (7 & ~(1 << m_col[i])) : 7;
        m_done[i] = 0;
        if (tick) begin
          if (m_up[i]) begin
            m_lvl[i] = (m_lvl[i] + steps[i] > 255) ? 255 : m_lvl[i] + steps[i];
            if (m_lvl[i] == 255) m_up[i] = 0;
          end else begin
            m_lvl[i] = (m_lvl[i] - steps[i] < 0) ? 0 : m_lvl[i] - steps[i];
            if (m_lvl[i] == 0) begin
              m_up[i] = 1;
              if (m_col[i] == 2) m_done[i] = 1;
              m_col[i] = (m_col[i] + 1) % 3;
            end
          end
        end
      end
      m_cnt = (m_cnt + 1) % 256;
    end else begin
      m_done[0] = 0;
      m_done[1] = 0;
    end
  end

  function automatic logic [2:0] rgb_of(input int d);
    return (d == 0) ? {a2, a1, a0} : {b2, b1, b0};
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_rgb_s1",    int'(rgb_of(0)), m_rgb[0]);
      chk("model_color_s1",  int'(ac),        m_col[0]);
      chk("model_done_s1",   int'(ad),        m_done[0]);
      chk("model_rgb_s100",  int'(rgb_of(1)), m_rgb[1]);
      chk("model_color_s100", int'(bc),       m_col[1]);
      chk("model_done_s100", int'(bd),        m_done[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  int lowcnt[3];
  task automatic count_low(input int d);
    logic [2:0] v;
    for (int k = 0; k < 3; k++) lowcnt[k] = 0;
    for (int k = 0; k < 256; k++) begin
      v = rgb_of(d);
      for (int c = 0; c < 3; c++) if (!v[c]) lowcnt[c]++;
      cyc();
    end
  endtask

  typedef struct {
    bit tk;
    int exp_lvl;
    int exp_col;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int bad, pulses, at;
    logic [2:0] s0, s1;
    logic [1:0] sc;

    tbl[0] = '{1, 100, 0};
    tbl[1] = '{1, 200, 0};
    tbl[2] = '{1, 255, 0};
    tbl[3] = '{1, 155, 0};
    tbl[4] = '{1,  55, 0};
    tbl[5] = '{1,   0, 1};
    tbl[6] = '{1, 100, 1};

    rst = 1'b1; en = 1'b0; tick = 1'b0;
    cyc(); cyc(); cyc();
    chk("reset_rgb_s1",   int'(rgb_of(0)), 7);
    chk("reset_rgb_s100", int'(rgb_of(1)), 7);
    chk("reset_color",    int'(ac), 0);
    chk("reset_done",     int'(ad), 0);
    rst = 1'b0;
    chk_on = 1;

    // Idle with no ticks: every LED stays off.
    en = 1'b1;
    bad = 0;
    repeat (600) begin
      if (rgb_of(0) != 3'b111 || rgb_of(1) != 3'b111 || ac != 2'd0) bad++;
      cyc();
    end
    chk("idle_600_all_off", bad, 0);

    // STEP=100 ramp measured as duty cycle on the active colour.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick = tbl[i].tk;
      cyc();
      tick = 1'b0;
      chk("tbl_color", int'(bc), tbl[i].exp_col);
      cyc();
      count_low(1);
      chk("tbl_level", lowcnt[tbl[i].exp_col], tbl[i].exp_lvl);
    end

    // STEP=1, 64 ticks: RGB0 low 64 of 256 cycles.
    do_reset();
    tick = 1'b1;
    repeat (64) cyc();
    tick = 1'b0;
    cyc();
    count_low(0);
    chk("duty64_rgb0", lowcnt[0], 64);
    chk("duty64_rgb1", lowcnt[1], 0);
    chk("duty64_rgb2", lowcnt[2], 0);

    // Ticks with en=0 are dropped and everything holds.
    s0 = rgb_of(0); s1 = rgb_of(1); sc = ac;
    en = 1'b0; tick = 1'b1;
    bad = 0;
    repeat (10) begin
      cyc();
      if (rgb_of(0) != s0 || rgb_of(1) != s1 || ac != sc) bad++;
    end
    chk("hold_en0", bad, 0);
    en = 1'b1; tick = 1'b0;
    cyc();
    count_low(0);
    chk("duty_after_hold", lowcnt[0], 64);

    // Reset mid-ramp, then the first tick gives level=STEP on RED.
    tick = 1'b1; rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_rgb_s1",   int'(rgb_of(0)), 7);
    chk("rst_mid_rgb_s100", int'(rgb_of(1)), 7);
    chk("rst_mid_color",    int'(ac), 0);
    cyc();
    tick = 1'b0;
    chk("post_rst_color", int'(ac), 0);
    cyc();
    count_low(0);
    chk("post_rst_level_s1", lowcnt[0], 1);
    count_low(1);
    chk("post_rst_level_s100", lowcnt[0], 100);

    // Full RED/GREEN/BLUE cycle at STEP=1: one seq_done on tick 1530.
    do_reset();
    tick = 1'b1;
    pulses = 0; at = 0;
    for (int i = 1; i <= 1530; i++) begin
      cyc();
      if (ad) begin
        pulses++;
        at = i;
      end
    end
    tick = 1'b0;
    chk("seq_done_pulses", pulses, 1);
    chk("seq_done_tick",   at, 1530);
    chk("seq_done_color",  int'(ac), 0);
    cyc();
    chk("seq_done_cleared", int'(ad), 0);
    count_low(0);
    chk("seq_end_level0", lowcnt[0] + lowcnt[1] + lowcnt[2], 0);

    // Random en/tick/rst against the model.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 399) == 0);
      en   = ($urandom_range(0, 4) != 0);
      tick = ($urandom_range(0, 2) == 0);
      cyc();
    end
    rst = 1'b0; tick = 1'b0;
    cyc();
    chk_on = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
